// File: rtl/seqgen_pkg.sv
// Shared types and constants for the sequence-generator burst arbiter.
// The optional per-burst generator restart is built when SEQGEN_ARB_RESTART_EN is defined.
package seqgen_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESTART = 2'd1,
      BURST   = 2'd2
   } seqgen_arb_state_t;

   localparam logic [7:0] SEQ_FIRST = 8'hAF;
   localparam int         SEQ_LEN   = 8;

   // Word sequence the generator produces after a reset, in order.
   localparam logic [7:0] SEQ_REF [SEQ_LEN] = '{
      8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
   };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after rr_ptr, wrapping.
module rr_arbiter
   import seqgen_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   int cand;

   // Walk the requesters starting at rr_ptr; the first hit wins and masks later ones.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = k + int'(rr_ptr);
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[cand[ID_W-1:0]]) begin
            found                = 1'b1;
            idx                  = cand[ID_W-1:0];
            gnt[cand[ID_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seqgen_burst_arbiter.sv
// Round-robin burst scheduler sharing one sequence generator between NUM_REQ requesters.
// Define SEQGEN_ARB_RESTART_EN to restart the generator before every burst.
module seqgen_burst_arbiter
   import seqgen_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     gen_enable,
   output logic                     gen_rst,
   input  logic [7:0]               gen_data,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_id,
   output logic                     out_last,
   output logic                     busy
);

   seqgen_arb_state_t  state;
   logic [LEN_W-1:0]   remaining;
   logic [ID_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_found;
   logic [LEN_W-1:0]   len_sel;

   // Zero-length requests are invisible to the arbiter so they can never win.
   always_comb begin
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = req[i] & (req_len[i*LEN_W +: LEN_W] != '0);
      end
   end

   assign len_sel = req_len[arb_idx*LEN_W +: LEN_W];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .gnt    (arb_gnt),
      .idx    (arb_idx),
      .found  (arb_found)
   );

   // The generator steps only on an accepted word, so a stall freezes out_data.
   assign out_data   = gen_data;
   assign gen_enable = out_valid & out_ready;
   assign out_last   = out_valid & (remaining == LEN_W'(1));

`ifdef SEQGEN_ARB_RESTART_EN
   assign gen_rst = rst_n | (state == RESTART);
`else
   assign gen_rst = rst_n;
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         out_id    <= '0;
         remaining <= '0;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  gnt       <= arb_gnt;
                  out_id    <= arb_idx;
                  remaining <= len_sel;
                  busy      <= 1'b1;
`ifdef SEQGEN_ARB_RESTART_EN
                  state     <= RESTART;
`else
                  state     <= BURST;
                  out_valid <= 1'b1;
`endif
               end
            end
`ifdef SEQGEN_ARB_RESTART_EN
            RESTART: begin
               state     <= BURST;
               out_valid <= 1'b1;
            end
`endif
            BURST: begin
               // Pointer moves past the finished requester so everyone else goes first.
               if (out_ready && remaining == LEN_W'(1)) begin
                  state     <= IDLE;
                  gnt       <= '0;
                  out_id    <= '0;
                  remaining <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  rr_ptr    <= (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + 1'b1;
               end else if (out_ready) begin
                  remaining <= remaining - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seqgen_burst_arbiter.sv
// Self-checking bench for seqgen_burst_arbiter with a behavioural generator and scheduler model.
// Honours SEQGEN_ARB_RESTART_EN the same way the design does.
module tb_seqgen_burst_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [3:0]  gnt;
   logic        gen_enable;
   logic        gen_rst;
   logic [7:0]  gen_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_id;
   logic        out_last;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   int m_seq  = 0;

   logic [7:0] seq_tab [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
   logic [2:0] gidx;

   seqgen_burst_arbiter #(
      .NUM_REQ (4),
      .LEN_W   (4),
      .ID_W    (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_len    (req_len),
      .gnt        (gnt),
      .gen_enable (gen_enable),
      .gen_rst    (gen_rst),
      .gen_data   (gen_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_last   (out_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the shared sequence generator.
   always @(posedge clk) begin
      if (gen_rst) gidx <= 3'd0;
      else if (gen_enable) gidx <= gidx + 3'd1;
   end
   assign gen_data = seq_tab[gidx];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed time budget exhausted, expected bench to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_gnt"},   32'(gnt), 0);
      checkOutput({tag, "_valid"}, 32'(out_valid), 0);
      checkOutput({tag, "_last"},  32'(out_last), 0);
      checkOutput({tag, "_id"},    32'(out_id), 0);
      checkOutput({tag, "_busy"},  32'(busy), 0);
      checkOutput({tag, "_gen_en"}, 32'(gen_enable), 0);
   endtask

   // One scheduling decision plus the resulting burst, predicted from round-robin rules.
   task automatic applyStimulus(input logic [3:0] rq, input logic [15:0] lens,
                                input logic [15:0] rdy_pat, input bit use_pat, input int abort_at);
      int win;
      int c;
      int rem;
      int j;
      int stalls;
      int accepted;
      logic rdy;
      win = -1;
      for (int k = 0; k < 4; k++) begin
         c = (m_ptr + k) % 4;
         if (win < 0 && rq[c] && lens[c*4 +: 4] != 4'd0) win = c;
      end
      req       = rq;
      req_len   = lens;
      out_ready = 1'b0;
      @(posedge clk); #1;
      if (win < 0) begin
         checkIdle("nogrant");
         return;
      end
      checkOutput("grant_onehot", 32'(gnt), 32'(1) << win);
      checkOutput("grant_id", 32'(out_id), win);
      checkOutput("grant_busy", 32'(busy), 1);
`ifdef SEQGEN_ARB_RESTART_EN
      checkOutput("restart_gen_rst", 32'(gen_rst), 1);
      checkOutput("restart_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      m_seq = 0;
`endif
      rem      = int'(lens[win*4 +: 4]);
      j        = 0;
      stalls   = 0;
      accepted = 0;
      while (rem > 0) begin
         if (use_pat) rdy = rdy_pat[j];
         else rdy = ($urandom_range(0, 3) != 0);
         if (stalls >= 3) rdy = 1'b1;
         out_ready = rdy;
         req       = 4'($urandom);
         req_len   = 16'($urandom);
         if (abort_at > 0 && accepted == abort_at) begin
            rst_n     = 1'b1;
            out_ready = 1'b1;
            #1;
            checkOutput("abort_no_last", 32'(out_last), 0);
            @(posedge clk); #1;
            checkIdle("abort");
            checkOutput("abort_gen_rst", 32'(gen_rst), 1);
            rst_n = 1'b0;
            m_ptr = 0;
            m_seq = 0;
            return;
         end
         #1;
         checkOutput("word_valid", 32'(out_valid), 1);
         checkOutput("word_data", 32'(out_data), 32'(seq_tab[m_seq]));
         checkOutput("word_last", 32'(out_last), (rem == 1) ? 1 : 0);
         checkOutput("word_gen_en", 32'(gen_enable), 32'(rdy));
         checkOutput("word_gen_rst", 32'(gen_rst), 0);
         checkOutput("word_id", 32'(out_id), win);
         checkOutput("word_gnt", 32'(gnt), 32'(1) << win);
         @(posedge clk); #1;
         if (rdy) begin
            rem--;
            accepted++;
            m_seq  = (m_seq + 1) % 8;
            stalls = 0;
         end else begin
            stalls++;
         end
         j++;
      end
      m_ptr = (win + 1) % 4;
      checkIdle("burst_end");
   endtask

   initial begin
      rst_n     = 1'b1;
      req       = '0;
      req_len   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      checkOutput("reset_gen_rst", 32'(gen_rst), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("release_gen_rst", 32'(gen_rst), 0);
      m_ptr = 0;
      m_seq = 0;

      $display("[TB] single request");
      applyStimulus(4'b0001, 16'h0003, 16'hFFFF, 1'b1, 0);
      $display("[TB] continuation");
      applyStimulus(4'b0010, 16'h0020, 16'hFFFF, 1'b1, 0);
      $display("[TB] round robin");
      for (int n = 0; n < 5; n++) applyStimulus(4'b1111, 16'h1111, 16'hFFFF, 1'b1, 0);
      $display("[TB] backpressure");
      applyStimulus(4'b0100, 16'h0400, 16'b0000_0000_0011_1001, 1'b1, 0);
      $display("[TB] zero length");
      applyStimulus(4'b0011, 16'h0010, 16'hFFFF, 1'b1, 0);
      applyStimulus(4'b1001, 16'h0000, 16'hFFFF, 1'b1, 0);
      $display("[TB] reset mid burst");
      applyStimulus(4'b0001, 16'h0005, 16'hFFFF, 1'b1, 1);
      applyStimulus(4'b1000, 16'h2000, 16'hFFFF, 1'b1, 0);
      $display("[TB] random");
      for (int n = 0; n < 30; n++) begin
         logic [15:0] lens;
         lens = '0;
         for (int i = 0; i < 4; i++) lens[i*4 +: 4] = 4'($urandom_range(0, 6));
         if (n == 10) lens[3:0] = 4'd15;
         applyStimulus(4'($urandom), lens, 16'h0000, 1'b0, 0);
      end

      req     = '0;
      req_len = '0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seqgen_burst_arbiter.md
# seqgen_burst_arbiter

Round-robin scheduler that shares one `sequence_generator` instance between `NUM_REQ` requesters. Each requester asks for a burst of N sequence words. The block grants one requester at a time and drives the generator's `enable` so that exactly one word advances per accepted transfer. It forwards the words over a valid/ready stream tagged with requester id and last-flag. It sits between the generator and its consumers and is the only block allowed to drive the generator's `enable`/reset.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `LEN_W`, 4, width of each burst-length field
- `ID_W`, `$clog2(NUM_REQ)`, width of `out_id`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-high reset (name kept consistent with `sequence_generator`)
- `req` in `NUM_REQ`: per-requester burst request, level
- `req_len` in `NUM_REQ*LEN_W`: burst length per requester, slice i = `[i*LEN_W +: LEN_W]`
- `gnt` out `NUM_REQ`: one-hot grant, held for the whole burst
- `gen_enable` out 1: to generator `enable`
- `gen_rst` out 1: to generator reset (active-high)
- `gen_data` in 8: generator `data`
- `out_data` out 8: forwarded word
- `out_valid` out 1: word valid
- `out_ready` in 1: consumer accepts
- `out_id` out `ID_W`: index of granted requester
- `out_last` out 1: final word of burst
- `busy` out 1: burst in progress

## Operation
- FSM states: IDLE, RESTART (only with macro), BURST.
- **IDLE**
  - Among `req[i]` with `req_len` slice ≠ 0, pick the first at or after `rr_ptr` (wrapping).
  - Register `gnt`, `out_id`, and `remaining = len`.
  - Next state: RESTART if the macro is defined, else BURST.
  - Requests with `len == 0` are never granted.
- **BURST**
  - `out_valid = 1`, `out_data = gen_data` (combinational pass-through).
  - `gen_enable = out_valid & out_ready`.
  - Each accept decrements `remaining`.
  - `out_last = (remaining == 1)`.
  - An accept with `out_last` high returns the FSM to IDLE, clears `gnt`, and sets `rr_ptr = granted index + 1 mod NUM_REQ`.
- **Stall:** `out_ready = 0` holds `out_data` stable (generator not enabled).
- **Request drop:** `req` deasserting mid-burst is ignored; the burst completes.
- **Request changes:** `req_len` changes after grant are ignored (latched).
- **Simultaneous requests:** resolved strictly by `rr_ptr`. No requester is granted twice while another has been waiting with a valid length.
- **Width:** `remaining` is `LEN_W` bits, so the maximum burst is 2^LEN_W − 1 words.
- **Outputs** are 0 in IDLE, except `gen_rst` (see Configuration).
- **Reset values:** `gnt = 0`, `gen_enable = 0`, `out_valid = 0`, `out_last = 0`, `out_id = 0`, `busy = 0`, `out_data = gen_data`, `rr_ptr = 0`, state IDLE, `gen_rst = 1`.
- **Reset mid-burst:** the burst is abandoned with no `out_last`, and the FSM is in IDLE on the next cycle.

## Timing
- Grant latency: `req` sampled in IDLE at edge k → `gnt` high after edge k.
- First `out_valid`: after edge k without the macro, after edge k+1 with it.
- Throughput: one word per cycle while `out_ready` is held high.
- Burst-to-burst gap: exactly one IDLE cycle (plus one RESTART cycle with the macro).
- `busy` is high in RESTART and BURST.
- The generator advances on the same edge that accepts a word, so the next `out_data` is valid in the following cycle.

## Configuration
- Macro: `SEQGEN_ARB_RESTART_EN`.
- **Defined:**
  - RESTART state asserts `gen_rst` for exactly one cycle before BURST.
  - Every burst therefore starts at 8'hAF.
  - `gen_rst` is also high while `rst_n` is high.
- **Undefined:**
  - `gen_rst = rst_n`.
  - The sequence continues across bursts and requesters.
  - There is no RESTART state.

## Structure
- Package `seqgen_pkg`:
  - state enum `seqgen_arb_state_t`
  - `SEQ_FIRST = 8'hAF`
  - `SEQ_LEN = 8`
  - reference sequence constant array: AF, BC, E2, 78, FF, E2, 0B, 8D
- One sub-module `rr_arbiter`:
  - combinational round-robin pick
  - inputs: `req` mask, `rr_ptr`
  - outputs: one-hot grant, index, found

## Test plan
- **Single request, macro undefined:** reset, then `req[0] = 1`, `len = 3`, `out_ready = 1` → words AF, BC, E2 with `out_id = 0` and `out_last` on E2; `gnt` drops the following cycle.
- **Continuation, macro undefined:** `req[1]` `len = 2` follows the previous burst → 78, FF; `out_id = 1`.
- **Restart, macro defined:** two consecutive bursts of `len = 2` from requesters 2 and 3 → AF, BC then AF, BC, with one `gen_rst` pulse before each.
- **Round-robin fairness:** `req = 4'b1111`, all `len = 1` → grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.
- **Backpressure:** `len = 4`, `out_ready` toggled 1, 0, 0, 1, 1, 1 → `out_data` held during stalls, `gen_enable` never high while `out_ready = 0`; output AF, BC, E2, 78.
- **Corner cases:** `req[0]` with `len = 0` plus `req[1]` with `len = 1` → only requester 1 is granted. Assert `rst_n` at the second word of a `len = 5` burst → all outputs return to reset values next cycle, and no `out_last` is issued.
